word_buffer_write_var: RTL and testbench
========================================

// Module: word_buffer_write_var
// PURPOSE
//  Bit packer: accepts variable-length bit fields (1..INPUTWIDTH bits per write) and
//  presents fixed OUTPUTWIDTH-bit words, FWFT, to a downstream word consumer.
//  It is the inverse of the variable-length-read word buffer, and sits on the ETROC2
//  readout TX side between the frame/field builders and the fixed-width serializer.
//  A flush FSM pads the trailing partial word so that every accepted bit is emitted.
// PARAMETERS
//  INPUTWIDTH   32    max field width per write; INPUTWIDTH+OUTPUTWIDTH <= 127
//  OUTPUTWIDTH  40    output word width
//  PADBIT       1'b0  fill value for bits appended by flush
// PORTS
//  clk          in   1           40MHz clock
//  rstn         in   1           reset, active low, asynchronous
//  wren         in   1           write request; accepted when full==0
//  writeLength  in   7           valid bits in din; 0 = no-op; >INPUTWIDTH is clamped to INPUTWIDTH
//  din          in   INPUTWIDTH  field data, LSB-first (din[0] is the earliest bit)
//  rden         in   1           read strobe; consumes one word when empty==0
//  flush        in   1           pulse: pad and drain the buffer
//  dout         out  OUTPUTWIDTH current word, combinational from the buffer (FWFT); dout[0] is the earliest bit
//  bitsCount    out  7           wrAddr - rdAddr, modulo 128
//  empty        out  1           no complete word is available
//  full         out  1           no room for a worst-case field
//  flushing     out  1           flush FSM is in PAD or DRAIN
// BEHAVIOUR
//  Storage and pointers
//  - Storage: 128-bit circular buffer cb; 7-bit pointers wrAddr and rdAddr wrap modulo 128.
//  - Accepted write: cb[(wrAddr+j)%128] <= din[j] for j < len; wrAddr += len.
//  - Accepted read: rdAddr += OUTPUTWIDTH. dout[k] = cb[(rdAddr+k)%128].
//  Status flags
//  - full = ((127-bitsCount) < INPUTWIDTH) | (state != IDLE). bitsCount never reaches 128.
//  - empty = bitsCount < OUTPUTWIDTH.
//  Handshake
//  - wren while full is ignored: no pointer or data change.
//  - rden while empty is ignored.
//  - A simultaneous write and read both take effect in the same edge.
//    Both flags are evaluated on the pre-edge bitsCount.
//  Flush FSM
//  - IDLE -> PAD on flush=1. A flush pulse while in PAD or DRAIN is ignored.
//  - PAD lasts 1 cycle. r = bitsCount % OUTPUTWIDTH, computed by a compare/subtract chain
//    with no divider. If r != 0, write (OUTPUTWIDTH-r) copies of PADBIT and advance wrAddr
//    by that amount. Reads are allowed in PAD; r is unaffected because reads are whole words.
//  - PAD -> DRAIN. DRAIN -> IDLE in the cycle after bitsCount==0.
//  - A flush with an empty buffer returns to IDLE 2 cycles later with no words produced.
//  Reset
//  - rstn=0 takes effect immediately (async): cb=0, wrAddr=rdAddr=0, state=IDLE.
//  - Output values in reset: dout=0, bitsCount=0, empty=1, full=0, flushing=0.
//  - A reset during PAD or DRAIN discards all pending bits.
//  - Deassertion takes effect at the next clk edge.
//  Latency
//  - A write is visible in bitsCount, empty and dout on the edge after acceptance.
//  - There is no output register.
// TESTING
//  T1 pack: 4 writes, len=10, din=3FF,000,155,2AA -> empty=0, dout=40'hAA955003FF,
//     bitsCount=40; then rden -> empty=1, bitsCount=0.
//  T2 wrap: random len 1..32, rden whenever !empty, 2000 cycles -> output bit stream
//     equals the model concatenation with no loss or duplication across pointer wrap.
//  T3 full: len=32 writes with rden=0 -> accepted at bitsCount 0,32,64; full=1 at 96;
//     a further wren leaves bitsCount=96 and cb unchanged.
//  T4 flush: write len=13 din=13'h1ABC, pulse flush -> flushing=1; bitsCount=40 after PAD;
//     dout[12:0]=13'h1ABC and dout[39:13]=0. rden -> bitsCount=0, and flushing=0 one cycle later.
//  T5 simultaneous: bitsCount=45, wren len=20 with rden in the same cycle -> bitsCount=25;
//     dout starts with bit 40 of the stream.
//  T6 async reset: assert rstn=0 mid-DRAIN between clk edges -> empty=1, full=0, flushing=0,
//     bitsCount=0 before the next clk edge.

Source files
------------

// File: rtl/word_buffer_write_var.sv
// word_buffer_write_var: variable-length bit packer.
// Variable-length fields are written LSB-first into a 128-bit circular buffer
// and read out as fixed OUTPUTWIDTH-bit words (first-word fall-through). A
// flush pads the trailing partial word with PADBIT so that every accepted bit
// leaves the buffer.
module word_buffer_write_var #(
  parameter int   INPUTWIDTH  = 32,
  parameter int   OUTPUTWIDTH = 40,
  parameter logic PADBIT      = 1'b0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wren,
  input  logic [6:0]             writeLength,
  input  logic [INPUTWIDTH-1:0]  din,
  input  logic                   rden,
  input  logic                   flush,
  output logic [OUTPUTWIDTH-1:0] dout,
  output logic [6:0]             bitsCount,
  output logic                   empty,
  output logic                   full,
  output logic                   flushing
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [6:0] IW7 = 7'(INPUTWIDTH);
  localparam logic [6:0] OW7 = 7'(OUTPUTWIDTH);
  // Enough subtract stages to reduce any 7-bit count below OUTPUTWIDTH.
  localparam int NSUB = 127 / OUTPUTWIDTH;

  logic [127:0] cb_q, cb_d;
  logic [6:0]   wr_addr_q, wr_addr_d;
  logic [6:0]   rd_addr_q, rd_addr_d;
  state_t       state_q;

  logic [6:0]   bits_s;
  logic [6:0]   space_s;
  logic         full_s;
  logic         empty_s;
  logic         wr_ok_s;
  logic         rd_ok_s;
  logic [6:0]   len_s;
  logic [6:0]   rem_s;
  logic [6:0]   pad_len_s;
  logic [6:0]   wlen_s;
  logic [127:0] wdata_s;
  logic [6:0]   off_s;

  // Occupancy and handshake flags, all derived from the pre-edge pointers.
  always_comb begin
    bits_s  = wr_addr_q - rd_addr_q;
    space_s = 7'd127 - bits_s;
    full_s  = (space_s < IW7) | (state_q != IDLE);
    empty_s = (bits_s < OW7);
    wr_ok_s = wren & ~full_s;
    rd_ok_s = rden & ~empty_s;
    if (writeLength > IW7) begin
      len_s = IW7;
    end else begin
      len_s = writeLength;
    end
  end

  // Remainder of the occupancy modulo OUTPUTWIDTH via a subtract chain.
  always_comb begin
    rem_s = bits_s;
    for (int i = 0; i < NSUB; i++) begin
      if (rem_s >= OW7) begin
        rem_s = rem_s - OW7;
      end else begin
        rem_s = rem_s;
      end
    end
    if (rem_s != 7'd0) begin
      pad_len_s = OW7 - rem_s;
    end else begin
      pad_len_s = 7'd0;
    end
  end

  // Select the write source: an accepted field, or padding during PAD.
  always_comb begin
    wdata_s = '0;
    if (wr_ok_s) begin
      wlen_s                   = len_s;
      wdata_s[INPUTWIDTH-1:0] = din;
    end else if (state_q == PAD) begin
      wlen_s  = pad_len_s;
      wdata_s = {128{PADBIT}};
    end else begin
      wlen_s = 7'd0;
    end
  end

  // Next buffer contents and pointers; each cell takes the bit at its offset from wrAddr.
  always_comb begin
    cb_d  = cb_q;
    off_s = 7'd0;
    for (int i = 0; i < 128; i++) begin
      off_s = 7'(i) - wr_addr_q;
      if (off_s < wlen_s) begin
        cb_d[i] = wdata_s[off_s];
      end else begin
        cb_d[i] = cb_q[i];
      end
    end
    wr_addr_d = wr_addr_q + wlen_s;
    if (rd_ok_s) begin
      rd_addr_d = rd_addr_q + OW7;
    end else begin
      rd_addr_d = rd_addr_q;
    end
  end

  // Storage, pointers and flush FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cb_q      <= '0;
      wr_addr_q <= 7'd0;
      rd_addr_q <= 7'd0;
      state_q   <= IDLE;
    end else begin
      cb_q      <= cb_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_q <= PAD;
          end else begin
            state_q <= IDLE;
          end
        end
        PAD: begin
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (bits_s == 7'd0) begin
            state_q <= IDLE;
          end else begin
            state_q <= DRAIN;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // FWFT word: the OUTPUTWIDTH bits starting at rdAddr, wrapping modulo 128.
  always_comb begin
    dout = '0;
    for (int k = 0; k < OUTPUTWIDTH; k++) begin
      dout[k] = cb_q[rd_addr_q + 7'(k)];
    end
  end

  // Status outputs.
  always_comb begin
    bitsCount = bits_s;
    empty     = empty_s;
    full      = full_s;
    flushing  = (state_q != IDLE);
  end

endmodule

// File: tb/tb_word_buffer_write_var.sv
// Self-checking bench for word_buffer_write_var: directed scenarios plus a
// randomized run against a bit-queue reference model.
module tb_word_buffer_write_var;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        wren = 1'b0;
  logic [6:0]  writeLength = 7'd0;
  logic [31:0] din = 32'd0;
  logic        rden = 1'b0;
  logic        flush = 1'b0;
  logic [39:0] dout;
  logic [6:0]  bitsCount;
  logic        empty;
  logic        full;
  logic        flushing;

  int tests = 0;
  int fails = 0;

  // Reference model: the stream of buffered bits, oldest first.
  bit q[$];
  bit mbusy = 1'b0;

  word_buffer_write_var #(.INPUTWIDTH(32), .OUTPUTWIDTH(40), .PADBIT(1'b0)) dut (
    .clk(clk), .rstn(rstn), .wren(wren), .writeLength(writeLength), .din(din),
    .rden(rden), .flush(flush), .dout(dout), .bitsCount(bitsCount),
    .empty(empty), .full(full), .flushing(flushing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    logic [39:0] e, m;
    n = q.size();
    e = '0;
    m = '0;
    for (int k = 0; k < 40; k++) begin
      if (k < n) begin
        e[k] = q[k];
        m[k] = 1'b1;
      end
    end
    chk({tag, "_dout"}, dout & m, e);
    chk({tag, "_bits"}, bitsCount, n);
    chk({tag, "_empty"}, empty, (n < 40));
    chk({tag, "_full"}, full, ((127 - n) < 32) || mbusy);
  endtask

  task automatic step(input logic w, input int len, input logic [31:0] d,
                      input logic r, input logic f);
    bit wr_ok, rd_ok;
    int eff;
    wren = w; writeLength = 7'(len); din = d; rden = r; flush = f;
    rd_ok = r && (q.size() >= 40);
    wr_ok = w && !((127 - q.size()) < 32) && !mbusy;
    eff = (len > 32) ? 32 : len;
    @(posedge clk);
    #1;
    if (rd_ok) begin
      for (int k = 0; k < 40; k++) void'(q.pop_front());
    end
    if (wr_ok) begin
      for (int j = 0; j < eff; j++) q.push_back(d[j]);
    end
    wren = 1'b0; writeLength = 7'd0; din = 32'd0; rden = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    #1 rstn = 1'b0;
    #1;
    chk("rst_dout", dout, 40'd0);
    chk("rst_bits", bitsCount, 7'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_flushing", flushing, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    mbusy = 1'b0;
  endtask

  initial begin
    bit r;
    do_reset();

    // T1: pack four 10-bit fields into one word
    step(1'b1, 10, 32'h3FF, 1'b0, 1'b0);
    step(1'b1, 10, 32'h000, 1'b0, 1'b0);
    step(1'b1, 10, 32'h155, 1'b0, 1'b0);
    step(1'b1, 10, 32'h2AA, 1'b0, 1'b0);
    check_model("t1");
    chk("t1_word", dout, 40'hAA955003FF);
    chk("t1_bits40", bitsCount, 7'd40);
    step(1'b0, 0, 32'd0, 1'b1, 1'b0);
    check_model("t1_rd");
    chk("t1_bits0", bitsCount, 7'd0);

    // T3: fill until full, then an ignored write
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32, $urandom, 1'b0, 1'b0);
      check_model("t3_fill");
    end
    chk("t3_full", full, 1'b1);
    step(1'b1, 32, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_model("t3_ignored");
    chk("t3_bits96", bitsCount, 7'd96);
    // oversize length is clamped to 32 after draining some room
    step(1'b0, 0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 45, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_model("t3_clamp");
    chk("t3_bits88", bitsCount, 7'd88);

    // T4: flush of a 13-bit partial word
    do_reset();
    step(1'b1, 13, 32'h1ABC, 1'b0, 1'b0);
    step(1'b0, 0, 32'd0, 1'b0, 1'b1);
    mbusy = 1'b1;
    chk("t4_flushing", flushing, 1'b1);
    check_model("t4_pad");
    step(1'b1, 20, 32'h12345, 1'b0, 1'b0);      // write during PAD is refused
    while ((q.size() % 40) != 0) q.push_back(1'b0);
    check_model("t4_drain");
    chk("t4_word", dout, 40'h0000001ABC);
    chk("t4_bits40", bitsCount, 7'd40);
    step(1'b0, 0, 32'd0, 1'b1, 1'b1);           // second flush pulse ignored
    check_model("t4_read");
    chk("t4_still_flushing", flushing, 1'b1);
    step(1'b0, 0, 32'd0, 1'b0, 1'b0);
    mbusy = 1'b0;
    chk("t4_idle", flushing, 1'b0);
    check_model("t4_done");

    // flush with an empty buffer
    step(1'b0, 0, 32'd0, 1'b0, 1'b1);
    chk("ef_pad", flushing, 1'b1);
    step(1'b0, 0, 32'd0, 1'b0, 1'b0);
    chk("ef_drain", flushing, 1'b1);
    step(1'b0, 0, 32'd0, 1'b0, 1'b0);
    chk("ef_idle", flushing, 1'b0);
    chk("ef_bits", bitsCount, 7'd0);

    // T5: simultaneous write and read at 45 bits
    do_reset();
    step(1'b1, 32, $urandom, 1'b0, 1'b0);
    step(1'b1, 13, $urandom, 1'b0, 1'b0);
    chk("t5_bits45", bitsCount, 7'd45);
    step(1'b1, 20, $urandom, 1'b1, 1'b0);
    check_model("t5");
    chk("t5_bits25", bitsCount, 7'd25);

    // T6: asynchronous reset mid-DRAIN
    do_reset();
    step(1'b1, 32, $urandom, 1'b0, 1'b0);
    step(1'b1, 32, $urandom, 1'b0, 1'b0);
    step(1'b1, 16, $urandom, 1'b0, 1'b0);
    step(1'b0, 0, 32'd0, 1'b0, 1'b1);
    mbusy = 1'b1;
    step(1'b0, 0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 0, 32'd0, 1'b0, 1'b0);
    check_model("t6_drain");
    chk("t6_flushing", flushing, 1'b1);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("t6_empty", empty, 1'b1);
    chk("t6_full", full, 1'b0);
    chk("t6_flushing0", flushing, 1'b0);
    chk("t6_bits", bitsCount, 7'd0);
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    mbusy = 1'b0;

    // T2: randomized traffic across many pointer wraps
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 7) != 0);
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 40), $urandom, r, 1'b0);
      check_model("t2");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
